// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU controller.
// Control words are {no, xo, na, ic, nb, ci} for the external ALU.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int CTL_W  = 6;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_XOR = 4'd2,
        OP_OR  = 4'd3,
        OP_AND = 4'd4,
        OP_INC = 4'd5,
        OP_DEC = 4'd6,
        OP_NOT = 4'd7,
        OP_NEG = 4'd8,
        OP_SHL = 4'd9,
        OP_MUL = 4'd10
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL_SHL,
        S_MUL_ADD,
        S_DONE
    } state_e;

    typedef struct packed {
        logic no;
        logic xo;
        logic na;
        logic ic;
        logic nb;
        logic ci;
    } ctl_t;

    // Which operand the ALU sees on its B input during EXEC.
    typedef enum logic [1:0] {
        BSEL_Y,
        BSEL_ZERO,
        BSEL_X
    } bsel_e;

    localparam ctl_t CTL_ZERO = 6'b000000;
    localparam ctl_t CTL_ADD  = 6'b000000;
    localparam ctl_t CTL_SUB  = 6'b000011;
    localparam ctl_t CTL_XOR  = 6'b000100;
    localparam ctl_t CTL_OR   = 6'b010100;
    localparam ctl_t CTL_AND  = 6'b111111;
    localparam ctl_t CTL_INC  = 6'b000001;
    localparam ctl_t CTL_DEC  = 6'b000010;
    localparam ctl_t CTL_NOT  = 6'b000110;
    localparam ctl_t CTL_NEG  = 6'b001001;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake plus the control/operand bus to the external ALU.
interface alu_seq_if;
    import alu_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_op;
    logic [DATA_W-1:0]        in_a;
    logic [DATA_W-1:0]        in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_result;
    logic                     out_carry;
    logic [DATA_W-1:0]        alu_a;
    logic [DATA_W-1:0]        alu_b;
    logic [CTL_W-1:0]         alu_ctl;
    logic [DATA_W-1:0]        alu_out;
    logic                     alu_co;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, alu_out, alu_co,
        input  in_ready, out_valid, out_result, out_carry, alu_a, alu_b, alu_ctl
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, alu_out, alu_co,
        output in_ready, out_valid, out_result, out_carry, alu_a, alu_b, alu_ctl
    );

endinterface

// File: rtl/alu_ctl_decode.sv
// Opcode to ALU control word and B-operand select; reserved opcodes flagged invalid.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [3:0] op_i,
    output ctl_t       ctl_o,
    output bsel_e      bsel_o,
    output logic       valid_o
);

    always_comb begin
        ctl_o   = CTL_ZERO;
        bsel_o  = BSEL_Y;
        valid_o = 1'b1;
        case (op_i)
            OP_ADD: ctl_o = CTL_ADD;
            OP_SUB: ctl_o = CTL_SUB;
            OP_XOR: ctl_o = CTL_XOR;
            OP_OR:  ctl_o = CTL_OR;
            OP_AND: ctl_o = CTL_AND;
            OP_INC: begin ctl_o = CTL_INC; bsel_o = BSEL_ZERO; end
            OP_DEC: begin ctl_o = CTL_DEC; bsel_o = BSEL_ZERO; end
            OP_NOT: begin ctl_o = CTL_NOT; bsel_o = BSEL_ZERO; end
            OP_NEG: begin ctl_o = CTL_NEG; bsel_o = BSEL_ZERO; end
            // Shift left is x + x through the adder.
            OP_SHL: begin ctl_o = CTL_ADD; bsel_o = BSEL_X; end
            OP_MUL: ctl_o = CTL_ADD;
            default: begin
                bsel_o  = BSEL_ZERO;
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequencer that drives an external ALU: single-pass ops in one EXEC cycle,
// MUL as MSB-first shift-and-add over 16 bits of the multiplier.
module alu_seq
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] p_q, p_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              carry_q, carry_d;

    ctl_t              dec_ctl;
    bsel_e             dec_bsel;
    logic              dec_valid;
    logic [CTL_W-1:0]  alu_ctl_c;
    logic [DATA_W-1:0] alu_a_c;
    logic [DATA_W-1:0] alu_b_c;

    alu_ctl_decode u_dec (
        .op_i    (op_q),
        .ctl_o   (dec_ctl),
        .bsel_o  (dec_bsel),
        .valid_o (dec_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        carry_d   = carry_q;
        alu_ctl_c = '0;
        alu_a_c   = '0;
        alu_b_c   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_op;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    p_d     = '0;
                    cnt_d   = 4'd15;
                    carry_d = 1'b0;
                    state_d = (bus.in_op == OP_MUL) ? S_MUL_SHL : S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = '0;
                carry_d = 1'b0;
                if (dec_valid) begin
                    alu_ctl_c = dec_ctl;
                    alu_a_c   = a_q;
                    case (dec_bsel)
                        BSEL_Y:  alu_b_c = b_q;
                        BSEL_X:  alu_b_c = a_q;
                        default: alu_b_c = '0;
                    endcase
                    res_d   = bus.alu_out;
                    carry_d = bus.alu_co;
                end
                state_d = S_DONE;
            end
            S_MUL_SHL: begin
                alu_ctl_c = CTL_ADD;
                alu_a_c   = p_q;
                alu_b_c   = p_q;
                p_d       = bus.alu_out;
                carry_d   = carry_q | bus.alu_co;
                if (b_q[cnt_q]) begin
                    state_d = S_MUL_ADD;
                end else if (cnt_q == 4'd0) begin
                    res_d   = bus.alu_out;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_MUL_ADD: begin
                alu_ctl_c = CTL_ADD;
                alu_a_c   = p_q;
                alu_b_c   = a_q;
                p_d       = bus.alu_out;
                carry_d   = carry_q | bus.alu_co;
                if (cnt_q == 4'd0) begin
                    res_d   = bus.alu_out;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = S_MUL_SHL;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = res_q;
    assign bus.out_carry  = carry_q;
    assign bus.alu_ctl    = alu_ctl_c;
    assign bus.alu_a      = alu_a_c;
    assign bus.alu_b      = alu_b_c;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: models the external ALU, checks results against arithmetic reference.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if bus();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // External ALU: {no, xo, na, ic, nb, ci}
    function automatic logic [16:0] ext_alu(logic [5:0] ctl, logic [15:0] a, logic [15:0] b);
        logic [15:0] x, y, r;
        logic        co;
        logic [16:0] s;
        x = ctl[3] ? ~a : a;
        y = ctl[1] ? ~b : b;
        if (ctl[2]) begin
            r  = ctl[4] ? (x | y) : (x ^ y);
            co = 1'b0;
        end else begin
            s  = {1'b0, x} + {1'b0, y} + {16'd0, ctl[0]};
            r  = s[15:0];
            co = s[16];
        end
        if (ctl[5]) r = ~r;
        return {co, r};
    endfunction

    always_comb {bus.alu_co, bus.alu_out} = ext_alu(bus.alu_ctl, bus.alu_a, bus.alu_b);

    // Reference: what each opcode means arithmetically.
    task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] r, output logic c);
        int unsigned ua, ub, s;
        ua = a;
        ub = b;
        r  = '0;
        c  = 1'b0;
        case (op)
            4'd0:  begin s = ua + ub; r = s[15:0]; c = (s > 65535); end
            4'd1:  begin r = a - b; c = (ua >= ub); end
            4'd2:  r = a ^ b;
            4'd3:  r = a | b;
            4'd4:  r = a & b;
            4'd5:  begin r = a + 16'd1; c = (ua == 65535); end
            4'd6:  begin r = a - 16'd1; c = (ua != 0); end
            4'd7:  r = ~a;
            4'd8:  begin r = 16'd0 - a; c = (ua == 0); end
            4'd9:  begin s = ua * 2; r = s[15:0]; c = a[15]; end
            4'd10: begin s = ua * ub; r = s[15:0]; c = (s > 65535); end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction; spec_r/spec_c < 0 means no literal expectation.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int hold, input int spec_r, input int spec_c);
        logic [15:0] er;
        logic        ec;
        int          lat, exp_lat;
        ref_model(op, a, b, er, ec);
        bus.out_ready = (hold == 0);
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        check($sformatf("%s_in_ready", tag), 32'(bus.in_ready), 32'd1);
        tick;
        bus.in_valid = 1'b0;
        bus.in_op    = 4'($urandom);
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick;
            lat++;
        end
        exp_lat = (op == 4'd10) ? 17 + $countones(b) : 2;
        check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_result", tag), 32'(bus.out_result), 32'(er));
        check($sformatf("%s_carry", tag), 32'(bus.out_carry), 32'(ec));
        if (spec_r >= 0) check($sformatf("%s_spec_result", tag), 32'(bus.out_result), 32'(spec_r));
        if (spec_c >= 0) check($sformatf("%s_spec_carry", tag), 32'(bus.out_carry), 32'(spec_c));
        check($sformatf("%s_done_busy", tag), 32'(bus.in_ready), 32'd0);
        check($sformatf("%s_done_ctl", tag), {bus.alu_ctl, bus.alu_a, bus.alu_b}, 32'd0);
        if (hold > 0) begin
            bus.in_op    = 4'd0;
            bus.in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick;
                check($sformatf("%s_hold_valid", tag), 32'(bus.out_valid), 32'd1);
                check($sformatf("%s_hold_result", tag), {15'd0, bus.out_carry, bus.out_result}, {15'd0, ec, er});
                check($sformatf("%s_hold_busy", tag), 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
        end
        tick;
        check($sformatf("%s_back_idle", tag), 32'(bus.in_ready), 32'd1);
        check($sformatf("%s_valid_drop", tag), 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int vcount;
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        tick;
        tick;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_carry", 32'(bus.out_carry), 32'd0);
        check("rst_alu_ctl", 32'(bus.alu_ctl), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        rst = 1'b0;
        tick;

        run_op("add_9_8",    4'd0,  16'd9,     16'd8,   0, 17,    0);
        run_op("add_wrap",   4'd0,  16'd65534, 16'd2,   0, 0,     1);
        run_op("sub_10_4",   4'd1,  16'd10,    16'd4,   0, 6,     -1);
        run_op("or_10_9",    4'd3,  16'd10,    16'd9,   0, 11,    -1);
        run_op("and_10_9",   4'd4,  16'd10,    16'd9,   0, 8,     -1);
        run_op("neg_16",     4'd8,  16'd16,    16'd0,   0, 65520, -1);
        run_op("mul_7_6",    4'd10, 16'd7,     16'd6,   0, 42,    0);
        run_op("mul_300",    4'd10, 16'd300,   16'd300, 0, 24464, 1);
        run_op("backpress",  4'd2,  16'h1234,  16'h0FF0, 5, -1,   -1);
        run_op("reserved13", 4'd13, 16'hBEEF,  16'h1111, 0, 0,     0);

        // Reset in the middle of a long multiply.
        bus.in_op    = 4'd10;
        bus.in_a     = 16'hFFFF;
        bus.in_b     = 16'hFFFF;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (7) tick;
        check("midmul_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midmul_rst_valid", 32'(bus.out_valid), 32'd0);
        check("midmul_rst_ready", 32'(bus.in_ready), 32'd1);
        check("midmul_rst_ctl", {bus.alu_ctl, bus.alu_a, bus.alu_b}, 32'd0);
        #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.out_valid) vcount++;
        end
        check("midmul_no_result", 32'(vcount), 32'd0);
        run_op("add_1_1", 4'd0, 16'd1, 16'd1, 0, 2, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (i % 4 == 0) ra = 16'($urandom_range(0, 300));
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, int'($urandom_range(0, 2)), -1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL run on one clock with asynchronous, active-high reset; ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when both high
- in_op  in  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 INC, 6 DEC, 7 NOT, 8 NEG, 9 SHL, 10 MUL, 11-15 reserved
- in_a, in_b  in  16 each  operands
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when both high
- out_result  out  16  result
- out_carry  out  1  carry/overflow
- alu_a, alu_b  out  16 each  operands to ALU
- alu_ctl  out  6  {no, xo, na, ic, nb, ci} to ALU
- alu_out  in  16  ALU result
- alu_co  in  1  ALU carry out

Function
REQ-002 The block SHALL have states IDLE, EXEC, MUL_SHL, MUL_ADD and DONE.
REQ-003 in_ready SHALL be 1 only in IDLE; on in_valid&&in_ready it SHALL latch op/a/b: MUL goes to MUL_SHL, all other ops go to EXEC.
REQ-004 In EXEC, alu_ctl/alu_a/alu_b SHALL be driven per op (x = latched a, y = latched b):
- ADD 000000 (x, y); SUB 000011 (x, y); XOR 000100 (x, y); OR 010100 (x, y); AND 111111 (x, y)
- INC 000001 (x, 0); DEC 000010 (x, 0); NOT 000110 (x, 0); NEG 001001 (x, 0); SHL 000000 (x, x)
REQ-005 EXEC SHALL last one cycle and register alu_out/alu_co into out_result/out_carry at its end; reserved ops SHALL register 0/0.
REQ-006 MUL SHALL iterate bit i = 15 down to 0:
- MUL_SHL drives 000000 with (p, p) and sets p = alu_out.
- If y[i] = 1, MUL_ADD follows and drives 000000 with (p, x), setting p = alu_out.
- p starts at 0.
REQ-007 MUL out_carry SHALL be the OR of alu_co over every MUL pass (equals product >= 65536); out_result SHALL be the low 16 bits.
REQ-008 Latency: accept in cycle N, then out_valid first high in cycle N+2 for single ops and N+17+popcount(y) for MUL.
REQ-009 DONE SHALL hold out_valid=1 and out_result/out_carry stable until out_ready=1, then go to IDLE; no new request is accepted in that same cycle.
REQ-010 Outside EXEC/MUL_* states, alu_ctl, alu_a and alu_b SHALL be 0.
REQ-011 in_op/in_a/in_b changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-012 rst SHALL force IDLE immediately, including mid-MUL or in DONE, discarding the operation in flight.
REQ-013 Reset values SHALL be: in_ready=1, out_valid=0, out_result=0, out_carry=0, alu_ctl=0, alu_a=0, alu_b=0, with internal product and bit counter 0.

Structure
REQ-014 A shared package alu_pkg SHALL hold the opcode enum, state enum, the 6-bit control-word type and per-op control constants.
REQ-015 One combinational sub-module alu_ctl_decode SHALL map opcode to control word and operand-B select; the ALU itself stays external.

Verification
REQ-016 ADD a=9 b=8 -> out_result=17, out_carry=0, out_valid at N+2.
REQ-017 ADD 65534+2 -> 0, carry 1; SUB 10-4 -> 6; OR 10,9 -> 11; AND 10,9 -> 8; NEG 16 -> 65520.
REQ-018 MUL 7*6 -> 42, carry 0, out_valid at N+19; MUL 300*300 -> 24464, carry 1.
REQ-019 Backpressure: out_ready low 5 cycles after out_valid -> result held, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-020 rst pulsed at cycle N+8 of a MUL -> out_valid=0, in_ready=1 next cycle; a following ADD 1+1 returns 2.
REQ-021 Reserved op 13 -> out_result=0, out_carry=0 at N+2; in_a changed after accept -> result unaffected.
